// File: rtl/riffa2ahir_pkg.sv
// Shared types for the RIFFA <-> AHIR bridge: FSM encodings and the
// conversion from 32-bit word counts to bus beats.
package riffa2ahir_pkg;

   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_ACK  = 2'd1,
      RX_DATA = 2'd2
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_FILL = 2'd1,
      TX_REQ  = 2'd2,
      TX_DATA = 2'd3
   } tx_state_e;

   localparam int WORD_BITS = 32;

   // Round up so that a partially filled last beat still counts as a beat.
   function automatic logic [31:0] words_to_beats(input logic [31:0] words,
                                                  input int         beat_bits);
      logic [32:0] words_per_beat;
      logic [32:0] padded;
      words_per_beat = 33'(beat_bits / WORD_BITS);
      padded         = {1'b0, words} + words_per_beat - 33'd1;
      return 32'(padded / words_per_beat);
   endfunction

endpackage

// File: rtl/riffa2ahir_fifo.sv
// Synchronous FIFO with full/empty flags; push and pop may coincide at any
// occupancy, including full and empty.
module riffa2ahir_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && (!empty_o || push_i);

   assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
   assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

   // On empty the incoming word is the head, so a same-cycle pop sees it.
   assign rdata_o = empty_o ? wdata_i : mem_q[rd_ptr_q[AW-1:0]];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define
   // which entries are valid, so the array can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/riffa2ahir_bridge.sv
// Bridges one RIFFA channel to an AHIR input/output pipe pair, buffering
// each direction in its own FIFO.
module riffa2ahir_bridge
   import riffa2ahir_pkg::*;
#(
   parameter int C_PCI_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH       = 16,
   parameter int TX_DATA_LEN      = 2,
   parameter int MODE             = 0
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic                        CHNL_RX,
   output logic                        CHNL_RX_ACK,
   input  logic [31:0]                 CHNL_RX_LEN,
   input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
   input  logic                        CHNL_RX_DATA_VALID,
   output logic                        CHNL_RX_DATA_REN,
   output logic                        CHNL_TX,
   input  logic                        CHNL_TX_ACK,
   output logic [31:0]                 CHNL_TX_LEN,
   output logic                        CHNL_TX_LAST,
   output logic [30:0]                 CHNL_TX_OFF,
   output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
   output logic                        CHNL_TX_DATA_VALID,
   input  logic                        CHNL_TX_DATA_REN,
   output logic [C_PCI_DATA_WIDTH-1:0] in_data_pipe_write_data,
   output logic                        in_data_pipe_write_req,
   input  logic                        in_data_pipe_write_ack,
   input  logic [C_PCI_DATA_WIDTH-1:0] out_data_pipe_read_data,
   output logic                        out_data_pipe_read_req,
   input  logic                        out_data_pipe_read_ack
);

   localparam int             CW         = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0]  TX_BEATS   = CW'(words_to_beats(32'(TX_DATA_LEN), C_PCI_DATA_WIDTH));
   localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

   rx_state_e   rx_state_q, rx_state_d;
   tx_state_e   tx_state_q, tx_state_d;
   logic [31:0] rx_cnt_q, rx_cnt_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;

   logic rx_push, rx_pop, rx_full, rx_empty;
   logic tx_push, tx_pop, tx_full, tx_empty;
   logic rx_done;

   assign CHNL_TX_LEN  = 32'(TX_DATA_LEN);
   assign CHNL_TX_LAST = 1'b1;
   assign CHNL_TX_OFF  = '0;

   assign rx_push = CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN;
   assign rx_pop  = in_data_pipe_write_req && in_data_pipe_write_ack;
   assign tx_push = out_data_pipe_read_req && out_data_pipe_read_ack;
   assign tx_pop  = CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN;

   assign in_data_pipe_write_req = !rx_empty;

   // NOTE: every output of a combinational block gets a default before the
   // case statement; a path that skipped an assignment would infer a latch.
   always_comb begin
      rx_state_d       = rx_state_q;
      rx_cnt_d         = rx_cnt_q;
      CHNL_RX_ACK      = 1'b0;
      CHNL_RX_DATA_REN = 1'b0;
      case (rx_state_q)
         RX_IDLE: if (CHNL_RX) rx_state_d = RX_ACK;
         RX_ACK: begin
            CHNL_RX_ACK = 1'b1;
            rx_cnt_d    = words_to_beats(CHNL_RX_LEN, C_PCI_DATA_WIDTH);
            rx_state_d  = (rx_cnt_d == 32'd0) ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            CHNL_RX_DATA_REN = !rx_full;
            if (CHNL_RX_DATA_VALID && !rx_full) rx_cnt_d = rx_cnt_q - 32'd1;
            if (rx_cnt_d == 32'd0 || !CHNL_RX) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Master mode launches a TX only on the cycle an RX transaction finishes.
   assign rx_done = (rx_state_q != RX_IDLE) && (rx_state_d == RX_IDLE);

   always_comb begin
      tx_state_d             = tx_state_q;
      tx_cnt_d               = tx_cnt_q;
      CHNL_TX                = 1'b0;
      CHNL_TX_DATA_VALID     = 1'b0;
      out_data_pipe_read_req = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (MODE != 0 || rx_done) tx_state_d = TX_FILL;
         end
         TX_FILL: begin
            out_data_pipe_read_req = !tx_full && (tx_cnt_q < TX_BEATS);
            if (out_data_pipe_read_req && out_data_pipe_read_ack) tx_cnt_d = tx_cnt_q + CNT_ONE;
            if (tx_cnt_d == TX_BEATS) tx_state_d = TX_REQ;
         end
         TX_REQ: begin
            CHNL_TX = 1'b1;
            if (CHNL_TX_ACK) tx_state_d = TX_DATA;
         end
         TX_DATA: begin
            CHNL_TX_DATA_VALID = !tx_empty;
            if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) tx_cnt_d = tx_cnt_q - CNT_ONE;
            if (tx_cnt_d == '0) tx_state_d = TX_IDLE;
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_state_q <= RX_IDLE;
         tx_state_q <= TX_IDLE;
         rx_cnt_q   <= '0;
         tx_cnt_q   <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         tx_state_q <= tx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         tx_cnt_q   <= tx_cnt_d;
      end
   end

   riffa2ahir_fifo #(
      .WIDTH (C_PCI_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk     (CLK),
      .rst_n   (RST_N),
      .push_i  (rx_push),
      .wdata_i (CHNL_RX_DATA),
      .pop_i   (rx_pop),
      .rdata_o (in_data_pipe_write_data),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );

   riffa2ahir_fifo #(
      .WIDTH (C_PCI_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk     (CLK),
      .rst_n   (RST_N),
      .push_i  (tx_push),
      .wdata_i (out_data_pipe_read_data),
      .pop_i   (tx_pop),
      .rdata_o (CHNL_TX_DATA),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

endmodule

// File: tb/tb_riffa2ahir_bridge.sv
// Bench for riffa2ahir_bridge: master 32-bit, slave 32-bit and master 64-bit
// instances driven by host/AHIR models with scoreboards.
module tb_riffa2ahir_bridge;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout or unexpected event, required normal completion", name);
   endtask

   // ---------------- u_m0: MODE 0, 32-bit ----------------
   logic        a_rx, a_rx_ack, a_rx_valid, a_rx_ren;
   logic [31:0] a_rx_len, a_rx_data;
   logic        a_tx, a_tx_ack, a_tx_last, a_tx_valid, a_tx_ren;
   logic [31:0] a_tx_len, a_tx_data;
   logic [30:0] a_tx_off;
   logic [31:0] a_wr_data, a_rd_data;
   logic        a_wr_req, a_wr_ack, a_rd_req, a_rd_ack;

   riffa2ahir_bridge #(.C_PCI_DATA_WIDTH(32), .FIFO_DEPTH(16), .TX_DATA_LEN(2), .MODE(0)) u_m0 (
      .CLK(clk), .RST_N(rst_n),
      .CHNL_RX(a_rx), .CHNL_RX_ACK(a_rx_ack), .CHNL_RX_LEN(a_rx_len), .CHNL_RX_DATA(a_rx_data),
      .CHNL_RX_DATA_VALID(a_rx_valid), .CHNL_RX_DATA_REN(a_rx_ren),
      .CHNL_TX(a_tx), .CHNL_TX_ACK(a_tx_ack), .CHNL_TX_LEN(a_tx_len), .CHNL_TX_LAST(a_tx_last),
      .CHNL_TX_OFF(a_tx_off), .CHNL_TX_DATA(a_tx_data), .CHNL_TX_DATA_VALID(a_tx_valid),
      .CHNL_TX_DATA_REN(a_tx_ren),
      .in_data_pipe_write_data(a_wr_data), .in_data_pipe_write_req(a_wr_req),
      .in_data_pipe_write_ack(a_wr_ack),
      .out_data_pipe_read_data(a_rd_data), .out_data_pipe_read_req(a_rd_req),
      .out_data_pipe_read_ack(a_rd_ack));

   logic [31:0] a_wr_exp[$];
   logic [31:0] a_src[$];
   logic [31:0] a_tx_exp[$];
   int a_wr_cnt = 0, a_txn_cnt = 0, a_tx_beats = 0, a_acc = 0;
   bit a_wack_block = 1'b0;

   // AHIR sink: random write_ack unless blocked, scoreboard compare on transfer.
   always begin
      @(negedge clk);
      a_wr_ack = !a_wack_block && ($urandom_range(0, 3) != 0);
      #4;
      if (a_wr_req && a_wr_ack) begin
         a_wr_cnt++;
         if (a_wr_exp.size() == 0) fail("a_wr_unexpected");
         else check("a_wr_data", a_wr_data, a_wr_exp.pop_front());
      end
   end

   // AHIR source and RIFFA TX host.
   always begin
      @(negedge clk);
      a_rd_ack  = (a_src.size() != 0);
      a_rd_data = a_rd_ack ? a_src[0] : 32'h0;
      a_tx_ack  = a_tx;
      a_tx_ren  = ($urandom_range(0, 3) != 0);
      #4;
      if (a_rd_req && a_rd_ack) a_tx_exp.push_back(a_src.pop_front());
      if (a_tx && a_tx_ack) begin
         a_txn_cnt++;
         check("a_tx_len", a_tx_len, 32'd2);
         check("a_tx_last_off", {a_tx_last, a_tx_off}, {1'b1, 31'd0});
      end
      if (a_tx_valid && a_tx_ren) begin
         a_tx_beats++;
         if (a_tx_exp.size() == 0) fail("a_tx_unexpected_beat");
         else check("a_tx_data", a_tx_data, a_tx_exp.pop_front());
      end
   end

   // Drive one RX transaction; stops early once stop_after beats were accepted.
   task automatic rx_send(input int len, input int stop_after, input logic [31:0] base);
      int t;
      a_acc = 0;
      @(negedge clk);
      a_rx     = 1'b1;
      a_rx_len = 32'(len);
      t = 0;
      while (1) begin
         @(negedge clk);
         #4;
         if (a_rx_ack) break;
         if (++t > 20) begin
            fail("a_rx_ack_timeout");
            a_rx = 1'b0;
            return;
         end
      end
      @(negedge clk);
      if (len == 0) a_rx = 1'b0;
      a_rx_valid = (len != 0);
      a_rx_data  = base;
      #4;
      check("a_rx_ack_pulse", a_rx_ack, 1'b0);
      if (len == 0) check("a_rx_ren_len0", a_rx_ren, 1'b0);
      t = 0;
      while (a_acc < len) begin
         if (a_rx_ren) begin
            a_wr_exp.push_back(a_rx_data);
            a_acc++;
            if (a_acc == stop_after) return;
         end
         if (a_acc < len) begin
            @(negedge clk);
            a_rx_data = base * 32'(a_acc + 1);
            #4;
            if (++t > 400) begin
               fail("a_rx_beat_timeout");
               break;
            end
         end
      end
      @(negedge clk);
      a_rx       = 1'b0;
      a_rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input int target);
      int t;
      t = 0;
      while (a_txn_cnt < target || a_tx_exp.size() != 0 || a_wr_exp.size() != 0 || a_src.size() != 0) begin
         @(negedge clk);
         if (++t > 500) begin
            fail("a_wait_tx_timeout");
            return;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   // ---------------- u_m1: MODE 1, 32-bit ----------------
   logic        b_rx_ack, b_rx_ren, b_tx, b_tx_ack, b_tx_last, b_tx_valid;
   logic [31:0] b_tx_len, b_tx_data, b_wr_data, b_rd_data;
   logic [30:0] b_tx_off;
   logic        b_wr_req, b_rd_req, b_rd_ack;
   logic [31:0] b_src[$];
   logic [31:0] b_tx_exp[$];
   int b_txn_cnt = 0, b_tx_beats = 0;

   riffa2ahir_bridge #(.C_PCI_DATA_WIDTH(32), .FIFO_DEPTH(16), .TX_DATA_LEN(2), .MODE(1)) u_m1 (
      .CLK(clk), .RST_N(rst_n),
      .CHNL_RX(1'b0), .CHNL_RX_ACK(b_rx_ack), .CHNL_RX_LEN(32'd0), .CHNL_RX_DATA(32'd0),
      .CHNL_RX_DATA_VALID(1'b0), .CHNL_RX_DATA_REN(b_rx_ren),
      .CHNL_TX(b_tx), .CHNL_TX_ACK(b_tx_ack), .CHNL_TX_LEN(b_tx_len), .CHNL_TX_LAST(b_tx_last),
      .CHNL_TX_OFF(b_tx_off), .CHNL_TX_DATA(b_tx_data), .CHNL_TX_DATA_VALID(b_tx_valid),
      .CHNL_TX_DATA_REN(1'b1),
      .in_data_pipe_write_data(b_wr_data), .in_data_pipe_write_req(b_wr_req),
      .in_data_pipe_write_ack(1'b1),
      .out_data_pipe_read_data(b_rd_data), .out_data_pipe_read_req(b_rd_req),
      .out_data_pipe_read_ack(b_rd_ack));

   always begin
      @(negedge clk);
      b_rd_ack  = (b_src.size() != 0);
      b_rd_data = b_rd_ack ? b_src[0] : 32'h0;
      b_tx_ack  = b_tx;
      #4;
      if (b_rd_req && b_rd_ack) b_tx_exp.push_back(b_src.pop_front());
      if (b_tx && b_tx_ack) begin
         b_txn_cnt++;
         check("b_tx_len", b_tx_len, 32'd2);
      end
      if (b_tx_valid) begin
         b_tx_beats++;
         if (b_tx_exp.size() == 0) fail("b_tx_unexpected_beat");
         else check("b_tx_data", b_tx_data, b_tx_exp.pop_front());
      end
   end

   // ---------------- u_w64: MODE 0, 64-bit ----------------
   logic        c_rx, c_rx_ack, c_rx_valid, c_rx_ren;
   logic [31:0] c_rx_len, c_tx_len;
   logic [63:0] c_rx_data, c_tx_data, c_wr_data;
   logic        c_tx, c_tx_last, c_tx_valid, c_wr_req, c_rd_req;
   logic [30:0] c_tx_off;
   logic [63:0] c_wr_exp[$];
   int c_wr_cnt = 0, c_acc = 0;

   riffa2ahir_bridge #(.C_PCI_DATA_WIDTH(64), .FIFO_DEPTH(16), .TX_DATA_LEN(2), .MODE(0)) u_w64 (
      .CLK(clk), .RST_N(rst_n),
      .CHNL_RX(c_rx), .CHNL_RX_ACK(c_rx_ack), .CHNL_RX_LEN(c_rx_len), .CHNL_RX_DATA(c_rx_data),
      .CHNL_RX_DATA_VALID(c_rx_valid), .CHNL_RX_DATA_REN(c_rx_ren),
      .CHNL_TX(c_tx), .CHNL_TX_ACK(1'b0), .CHNL_TX_LEN(c_tx_len), .CHNL_TX_LAST(c_tx_last),
      .CHNL_TX_OFF(c_tx_off), .CHNL_TX_DATA(c_tx_data), .CHNL_TX_DATA_VALID(c_tx_valid),
      .CHNL_TX_DATA_REN(1'b0),
      .in_data_pipe_write_data(c_wr_data), .in_data_pipe_write_req(c_wr_req),
      .in_data_pipe_write_ack(1'b1),
      .out_data_pipe_read_data(64'd0), .out_data_pipe_read_req(c_rd_req),
      .out_data_pipe_read_ack(1'b0));

   always begin
      @(negedge clk);
      #4;
      if (c_wr_req) begin
         c_wr_cnt++;
         if (c_wr_exp.size() == 0) fail("c_wr_unexpected");
         else check("c_wr_data", c_wr_data, c_wr_exp.pop_front());
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      int          len;
      logic [31:0] base;
      logic [31:0] src0;
      logic [31:0] src1;
      int          exp_writes;
   } rx_vec_t;

   rx_vec_t vecs[4];

   initial begin : main
      int w0, x0, b0, t;

      vecs[0] = '{len: 4, base: 32'h11,  src0: 32'hA,    src1: 32'hB,    exp_writes: 4};
      vecs[1] = '{len: 0, base: 32'h99,  src0: 32'hC0,   src1: 32'hC1,   exp_writes: 0};
      vecs[2] = '{len: 1, base: 32'h7F,  src0: 32'hD0D0, src1: 32'hD1D1, exp_writes: 1};
      vecs[3] = '{len: 7, base: 32'h100, src0: 32'hE0,   src1: 32'hE1,   exp_writes: 7};

      a_rx = 1'b0; a_rx_len = '0; a_rx_data = '0; a_rx_valid = 1'b0;
      c_rx = 1'b0; c_rx_len = '0; c_rx_data = '0; c_rx_valid = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      #1;
      check("reset_handshakes", {a_rx_ack, a_rx_ren, a_tx, a_tx_valid, a_wr_req, a_rd_req, b_rd_req, b_tx}, 8'h0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("idle_m0_outputs", {a_rx_ack, a_rx_ren, a_tx, a_wr_req, a_rd_req}, 5'h0);
      check("idle_m0_consts", {a_tx_len, a_tx_last, a_tx_off}, {32'd2, 1'b1, 31'd0});
      check("m1_fill_after_reset", b_rd_req, 1'b1);
      check("m1_no_tx_without_data", b_txn_cnt, 0);

      // Table of master-mode RX transactions, each triggering one TX.
      for (int k = 0; k < 4; k++) begin
         w0 = a_wr_cnt; x0 = a_txn_cnt; b0 = a_tx_beats;
         a_src.push_back(vecs[k].src0);
         a_src.push_back(vecs[k].src1);
         repeat (3) @(negedge clk);
         check("m0_no_early_read", a_src.size(), 2);
         rx_send(vecs[k].len, -1, vecs[k].base);
         wait_tx(x0 + 1);
         check("vec_writes", a_wr_cnt - w0, vecs[k].exp_writes);
         check("vec_txns", a_txn_cnt - x0, 1);
         check("vec_tx_beats", a_tx_beats - b0, 2);
      end

      // Backpressure: AHIR stalls, RX FIFO fills to exactly 16 beats.
      w0 = a_wr_cnt; x0 = a_txn_cnt;
      a_wack_block = 1'b1;
      a_src.push_back(32'h5A);
      a_src.push_back(32'h5B);
      fork
         rx_send(20, -1, 32'h5);
         begin
            repeat (60) @(negedge clk);
            #4;
            check("bp_accepted", a_acc, 16);
            check("bp_ren_low", a_rx_ren, 1'b0);
            check("bp_no_writes", a_wr_cnt - w0, 0);
            a_wack_block = 1'b0;
         end
      join
      wait_tx(x0 + 1);
      check("bp_total_writes", a_wr_cnt - w0, 20);
      check("bp_txn", a_txn_cnt - x0, 1);

      // Slave mode: four AHIR beats give two back-to-back transactions.
      b_src.push_back(32'h1001); b_src.push_back(32'h1002);
      b_src.push_back(32'h1003); b_src.push_back(32'h1004);
      t = 0;
      while (b_tx_beats < 4 && t < 200) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      check("m1_txns", b_txn_cnt, 2);
      check("m1_beats", b_tx_beats, 4);

      // 64-bit bus: LEN=3 words rounds up to two beats.
      @(negedge clk);
      c_rx = 1'b1; c_rx_len = 32'd3;
      t = 0;
      while (1) begin
         @(negedge clk);
         #4;
         if (c_rx_ack) break;
         if (++t > 20) begin
            fail("c_rx_ack_timeout");
            break;
         end
      end
      @(negedge clk);
      c_rx_valid = 1'b1;
      c_rx_data  = 64'hA5A5_0000_0000_0000;
      #4;
      t = 0;
      while (c_acc < 2 && t < 100) begin
         if (c_rx_ren) begin
            c_wr_exp.push_back(c_rx_data);
            c_acc++;
         end
         if (c_acc < 2) begin
            @(negedge clk);
            c_rx_data = 64'hA5A5_0000_0000_0000 + 64'(c_acc);
            #4;
            t++;
         end
      end
      @(negedge clk);
      c_rx = 1'b0;
      c_rx_data = 64'hDEAD_BEEF_DEAD_BEEF;
      #4;
      check("w64_ren_after_last", c_rx_ren, 1'b0);
      @(negedge clk);
      c_rx_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("w64_beats", c_acc, 2);
      check("w64_writes", c_wr_cnt, 2);

      // Reset in the middle of an RX transaction.
      a_wack_block = 1'b1;
      rx_send(8, 3, 32'h21);
      @(negedge clk);
      rst_n = 1'b0;
      a_rx = 1'b0;
      a_rx_valid = 1'b0;
      a_wr_exp.delete();
      w0 = a_wr_cnt;
      #1;
      check("midrst_handshakes", {a_rx_ack, a_rx_ren, a_tx, a_tx_valid, a_wr_req, a_rd_req, b_rd_req, b_tx}, 8'h0);
      a_wack_block = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst_no_writes", a_wr_cnt - w0, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("postrst_no_writes", a_wr_cnt - w0, 0);

      w0 = a_wr_cnt; x0 = a_txn_cnt;
      a_src.push_back(32'h77);
      a_src.push_back(32'h88);
      rx_send(2, -1, 32'h31);
      wait_tx(x0 + 1);
      check("postrst_writes", a_wr_cnt - w0, 2);
      check("postrst_txn", a_txn_cnt - x0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
